// File: rtl/pipe_ctrl.sv
// Five-stage in-order pipeline controller: valid/allowin handshake, load-use interlock, branch flush, stall counter.
// Latency: an instruction valid in IF reaches WB four clocks later when no stage stalls; loads/flush are combinational.
// Backpressure: allowin ripples back from WB to IF in the same cycle; a stalled stage holds its valid and blocks the stage behind it.
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   // fetch / memory handshakes
   input  logic        inst_data_ok,
   input  logic        mem_dram_req,
   input  logic        mem_data_ok,
   input  logic        ex_br_taken,
   // ID source operands
   input  logic [4:0]  id_r1,
   input  logic [4:0]  id_r2,
   input  logic        id_use_r1,
   input  logic        id_use_r2,
   // EX producer
   input  logic [4:0]  ex_rd,
   input  logic        ex_rf_we,
   input  logic        ex_res_from_dram,
   // stage occupancy
   output logic        if_valid,
   output logic        id_valid,
   output logic        ex_valid,
   output logic        mem_valid,
   output logic        wb_valid,
   // pipeline-register capture enables
   output logic        id_load,
   output logic        ex_load,
   output logic        mem_load,
   output logic        wb_load,
   output logic        mem_ready_go,
   output logic        flush,
   output logic        load_use_stall,
   output logic [15:0] stall_cnt
);

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // stage occupancy and counter state
   logic        if_valid_q,  if_valid_d;
   logic        id_valid_q,  id_valid_d;
   logic        ex_valid_q,  ex_valid_d;
   logic        mem_valid_q, mem_valid_d;
   logic        wb_valid_q,  wb_valid_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // combinational handshake terms
   logic        hit_r1;
   logic        hit_r2;
   logic        lus_c;
   logic        flush_c;
   logic        if_ready_go;
   logic        id_ready_go;
   logic        mem_ready_go_c;
   logic        if_allowin;
   logic        id_allowin;
   logic        ex_allowin;
   logic        mem_allowin;
   logic        stall_evt;

   // Hazard detection and branch redirect: a load in EX whose destination an ID source needs
   // cannot be forwarded yet; a taken branch resolved in EX kills the younger IF/ID contents.
   always_comb begin
      hit_r1  = id_use_r1 && (id_r1 == ex_rd);
      hit_r2  = id_use_r2 && (id_r2 == ex_rd);
      lus_c   = id_valid_q && ex_valid_q && ex_rf_we && ex_res_from_dram &&
                (ex_rd != 5'd0) && (hit_r1 || hit_r2);
      flush_c = ex_valid_q && ex_br_taken;
   end

   // Ready-go and allowin chain, evaluated from WB backwards (WB always accepts, EX always completes).
   // A flush overrides the load-use interlock: the stalled ID instruction is wrong-path anyway,
   // so it is allowed to move and be squashed rather than holding the pipe.
   always_comb begin
      if_ready_go    = inst_data_ok;
      id_ready_go    = flush_c || !lus_c;
      // dram request only counts when MEM actually holds an instruction
      mem_ready_go_c = !(mem_valid_q && mem_dram_req) || mem_data_ok;

      mem_allowin    = !mem_valid_q || mem_ready_go_c;
      ex_allowin     = !ex_valid_q  || mem_allowin;
      id_allowin     = !id_valid_q  || (id_ready_go && ex_allowin);
      if_allowin     = !if_valid_q  || (if_ready_go && id_allowin);
   end

   // Next-state for stage valids and the stall counter; flush bubbles IF/ID and EX (if EX can take one).
   always_comb begin
      if_valid_d  = if_valid_q;
      id_valid_d  = id_valid_q;
      ex_valid_d  = ex_valid_q;
      mem_valid_d = mem_valid_q;
      wb_valid_d  = wb_valid_q;
      stall_cnt_d = stall_cnt_q;

      if (flush_c) begin
         if_valid_d = 1'b0;
         id_valid_d = 1'b0;
      end else begin
         if (if_allowin) begin
            if_valid_d = 1'b1;
         end
         if (id_allowin) begin
            id_valid_d = if_valid_q && if_ready_go;
         end
      end

      if (ex_allowin) begin
         ex_valid_d = flush_c ? 1'b0 : (id_valid_q && id_ready_go);
      end
      if (mem_allowin) begin
         mem_valid_d = ex_valid_q;
      end
      wb_valid_d = mem_valid_q && mem_ready_go_c;

      stall_evt = lus_c || (mem_valid_q && !mem_ready_go_c);
      if (stall_evt && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // State registers; reset clears occupancy and the counter immediately, dropping any pending stall or flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_valid_q  <= 1'b0;
         id_valid_q  <= 1'b0;
         ex_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         wb_valid_q  <= 1'b0;
         stall_cnt_q <= 16'd0;
      end else begin
         if_valid_q  <= if_valid_d;
         id_valid_q  <= id_valid_d;
         ex_valid_q  <= ex_valid_d;
         mem_valid_q <= mem_valid_d;
         wb_valid_q  <= wb_valid_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Capture enables: stage s loads when it can accept and its predecessor holds a finished instruction.
   // With all valids cleared by reset these are already low during reset.
   assign id_load        = id_allowin  && if_valid_q  && if_ready_go;
   assign ex_load        = ex_allowin  && id_valid_q  && id_ready_go;
   assign mem_load       = mem_allowin && ex_valid_q;
   assign wb_load        = mem_valid_q && mem_ready_go_c;

   assign if_valid       = if_valid_q;
   assign id_valid       = id_valid_q;
   assign ex_valid       = ex_valid_q;
   assign mem_valid      = mem_valid_q;
   assign wb_valid       = wb_valid_q;
   assign mem_ready_go   = mem_ready_go_c;
   assign flush          = flush_c;
   assign load_use_stall = lus_c;
   assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of per-cycle vectors plus hand sequences for flush-under-stall,
// asynchronous reset and counter saturation.
// Inputs change on the falling edge; outputs are compared 1 time unit later, before the next rising edge.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_data_ok, mem_dram_req, mem_data_ok, ex_br_taken;
   logic [4:0]  id_r1, id_r2, ex_rd;
   logic        id_use_r1, id_use_r2, ex_rf_we, ex_res_from_dram;
   logic        if_valid, id_valid, ex_valid, mem_valid, wb_valid;
   logic        id_load, ex_load, mem_load, wb_load;
   logic        mem_ready_go, flush, load_use_stall;
   logic [15:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   pipe_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .inst_data_ok     (inst_data_ok),
      .mem_dram_req     (mem_dram_req),
      .mem_data_ok      (mem_data_ok),
      .ex_br_taken      (ex_br_taken),
      .id_r1            (id_r1),
      .id_r2            (id_r2),
      .id_use_r1        (id_use_r1),
      .id_use_r2        (id_use_r2),
      .ex_rd            (ex_rd),
      .ex_rf_we         (ex_rf_we),
      .ex_res_from_dram (ex_res_from_dram),
      .if_valid         (if_valid),
      .id_valid         (id_valid),
      .ex_valid         (ex_valid),
      .mem_valid        (mem_valid),
      .wb_valid         (wb_valid),
      .id_load          (id_load),
      .ex_load          (ex_load),
      .mem_load         (mem_load),
      .wb_load          (wb_load),
      .mem_ready_go     (mem_ready_go),
      .flush            (flush),
      .load_use_stall   (load_use_stall),
      .stall_cnt        (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ctl;   // {inst_data_ok, mem_dram_req, mem_data_ok, ex_br_taken}
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [1:0]  use_r; // {id_use_r1, id_use_r2}
      logic [4:0]  rd;
      logic [1:0]  wd;    // {ex_rf_we, ex_res_from_dram}
      logic [4:0]  vld;   // {if, id, ex, mem, wb}
      logic [3:0]  ld;    // {id, ex, mem, wb}
      logic [2:0]  flg;   // {mem_ready_go, flush, load_use_stall}
      logic [15:0] cnt;
   } vec_t;

   localparam int NVEC = 23;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic [3:0] ctl, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [1:0] use_r, input logic [4:0] rd, input logic [1:0] wd,
                               input logic [4:0] vld, input logic [3:0] ld, input logic [2:0] flg,
                               input logic [15:0] cnt);
      vec_t v;
      v.ctl = ctl; v.r1 = r1; v.r2 = r2; v.use_r = use_r; v.rd = rd; v.wd = wd;
      v.vld = vld; v.ld = ld; v.flg = flg; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] ctl, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [1:0] use_r, input logic [4:0] rd, input logic [1:0] wd);
      {inst_data_ok, mem_dram_req, mem_data_ok, ex_br_taken} = ctl;
      id_r1 = r1;
      id_r2 = r2;
      {id_use_r1, id_use_r2} = use_r;
      ex_rd = rd;
      {ex_rf_we, ex_res_from_dram} = wd;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, " vld"},  {11'd0, if_valid, id_valid, ex_valid, mem_valid, wb_valid}, 16'd0);
      chk({tag, " ld"},   {12'd0, id_load, ex_load, mem_load, wb_load}, 16'd0);
      chk({tag, " fl"},   {15'd0, flush}, 16'd0);
      chk({tag, " lus"},  {15'd0, load_use_stall}, 16'd0);
      chk({tag, " cnt"},  stall_cnt, 16'd0);
   endtask

   initial begin
      // per-cycle vectors starting right after reset release; k-th entry is seen after k rising edges
      vecs[0]  = mk(4'b1000, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b00000, 4'b0000, 3'b100, 16'd0);
      vecs[1]  = mk(4'b1000, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b10000, 4'b1000, 3'b100, 16'd0);
      vecs[2]  = mk(4'b1000, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b11000, 4'b1100, 3'b100, 16'd0);
      vecs[3]  = mk(4'b1000, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b11100, 4'b1110, 3'b100, 16'd0);
      vecs[4]  = mk(4'b1000, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b11110, 4'b1111, 3'b100, 16'd0);
      // load-use on r1, then the bubble in EX
      vecs[5]  = mk(4'b1000, 5'd5, 5'd0, 2'b10, 5'd5, 2'b11, 5'b11111, 4'b0011, 3'b101, 16'd0);
      vecs[6]  = mk(4'b1000, 5'd5, 5'd0, 2'b10, 5'd5, 2'b11, 5'b11011, 4'b1101, 3'b100, 16'd1);
      // r0 destination never stalls
      vecs[7]  = mk(4'b1000, 5'd0, 5'd0, 2'b10, 5'd0, 2'b11, 5'b11101, 4'b1110, 3'b100, 16'd1);
      // r2 match but EX is not a load
      vecs[8]  = mk(4'b1000, 5'd0, 5'd7, 2'b01, 5'd7, 2'b10, 5'b11110, 4'b1111, 3'b100, 16'd1);
      // r2 match from a load
      vecs[9]  = mk(4'b1000, 5'd0, 5'd7, 2'b01, 5'd7, 2'b11, 5'b11111, 4'b0011, 3'b101, 16'd1);
      vecs[10] = mk(4'b1000, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b11011, 4'b1101, 3'b100, 16'd2);
      // matching registers but neither source used
      vecs[11] = mk(4'b1000, 5'd7, 5'd7, 2'b00, 5'd7, 2'b11, 5'b11101, 4'b1110, 3'b100, 16'd2);
      // no register write in EX
      vecs[12] = mk(4'b1000, 5'd9, 5'd0, 2'b10, 5'd9, 2'b01, 5'b11110, 4'b1111, 3'b100, 16'd2);
      // dram access outstanding three cycles, then completes
      vecs[13] = mk(4'b1100, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b11111, 4'b0000, 3'b000, 16'd2);
      vecs[14] = mk(4'b1100, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b11110, 4'b0000, 3'b000, 16'd3);
      vecs[15] = mk(4'b1100, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b11110, 4'b0000, 3'b000, 16'd4);
      vecs[16] = mk(4'b1110, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b11110, 4'b1111, 3'b100, 16'd5);
      // taken branch together with a load-use hazard
      vecs[17] = mk(4'b1001, 5'd5, 5'd0, 2'b10, 5'd5, 2'b11, 5'b11111, 4'b1111, 3'b111, 16'd5);
      vecs[18] = mk(4'b1000, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b00011, 4'b0001, 3'b100, 16'd6);
      // dram request with MEM empty is not a stall
      vecs[19] = mk(4'b1100, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b10001, 4'b1000, 3'b100, 16'd6);
      vecs[20] = mk(4'b1000, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b11000, 4'b1100, 3'b100, 16'd6);
      // fetch not complete: IF holds, ID gets a bubble
      vecs[21] = mk(4'b0000, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b11100, 4'b0110, 3'b100, 16'd6);
      vecs[22] = mk(4'b1000, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'b10110, 4'b1011, 3'b100, 16'd6);

      rst = 1'b1;
      drive(4'b1000, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00);
      @(posedge clk);
      #1;
      check_cleared("reset");
      #1 rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive(vecs[i].ctl, vecs[i].r1, vecs[i].r2, vecs[i].use_r, vecs[i].rd, vecs[i].wd);
         #1;
         chk($sformatf("v%0d vld", i), {11'd0, if_valid, id_valid, ex_valid, mem_valid, wb_valid},
             {11'd0, vecs[i].vld});
         chk($sformatf("v%0d ld", i), {12'd0, id_load, ex_load, mem_load, wb_load}, {12'd0, vecs[i].ld});
         chk($sformatf("v%0d flg", i), {13'd0, mem_ready_go, flush, load_use_stall}, {13'd0, vecs[i].flg});
         chk($sformatf("v%0d cnt", i), stall_cnt, vecs[i].cnt);
      end

      // flush while MEM is stalled: EX cannot take a bubble, so the branch stays in EX
      @(negedge clk);
      drive(4'b1000, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00);   // 1,1,0,1,1 -> 1,1,1,0,1
      @(negedge clk);                                   // 1,1,1,0,1 -> 1,1,1,1,0
      @(negedge clk);
      drive(4'b1101, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00);
      #1;
      chk("fs vld0", {11'd0, if_valid, id_valid, ex_valid, mem_valid, wb_valid}, 16'b11110);
      chk("fs flush0", {15'd0, flush}, 16'd1);
      chk("fs ld0", {12'd0, id_load, ex_load, mem_load, wb_load}, 16'd0);
      @(negedge clk);
      #1;
      chk("fs vld1", {11'd0, if_valid, id_valid, ex_valid, mem_valid, wb_valid}, 16'b00110);
      chk("fs flush1", {15'd0, flush}, 16'd1);
      chk("fs cnt", stall_cnt, 16'd7);
      // asynchronous reset in the middle of the flush/stall, no clock edge
      #1 rst = 1'b1;
      #1;
      check_cleared("rst mid flush");

      // counter saturation: full pipe, MEM stalled and a load-use hazard held every cycle
      @(negedge clk);
      rst = 1'b0;
      drive(4'b1000, 5'd0, 5'd0, 2'b00, 5'd0, 2'b00);
      repeat (4) @(negedge clk);
      drive(4'b1100, 5'd5, 5'd0, 2'b10, 5'd5, 2'b11);
      #1;
      chk("sat fill vld", {11'd0, if_valid, id_valid, ex_valid, mem_valid, wb_valid}, 16'b11110);
      chk("sat lus", {15'd0, load_use_stall}, 16'd1);
      repeat (65534) @(negedge clk);
      #1;
      chk("sat fffe", stall_cnt, 16'hFFFE);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("sat hold%0d", k), stall_cnt, 16'hFFFF);
      end
      chk("sat lus held", {15'd0, load_use_stall}, 16'd1);
      // reset during the stall clears everything without a clock edge
      rst = 1'b1;
      #1;
      check_cleared("rst mid stall");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 system clock; rst in 1 asynchronous active-high reset.
REQ-002 SHALL have inputs: inst_data_ok 1 (IF fetch complete); mem_dram_req 1 (MEM instr accesses dram); mem_data_ok 1 (dram access complete); ex_br_taken 1 (EX resolved taken branch).
REQ-003 SHALL have hazard inputs: id_r1 5, id_r2 5, id_use_r1 1, id_use_r2 1 (ID sources); ex_rd 5, ex_rf_we 1, ex_res_from_dram 1 (EX producer).
REQ-004 SHALL have outputs: if_valid, id_valid, ex_valid, mem_valid, wb_valid 1 each (stage occupancy).
REQ-005 SHALL have outputs: id_load, ex_load, mem_load, wb_load 1 each (pipeline-register capture enables); mem_ready_go 1; flush 1.
REQ-006 SHALL have outputs: load_use_stall 1; stall_cnt 16 (performance counter).

Function
REQ-007 ready_go: IF = inst_data_ok; ID = !load_use_stall; EX = 1; MEM = !mem_dram_req || mem_data_ok; WB = 1.
REQ-008 allowin: WB = 1; each other stage s = !valid_s || (ready_go_s && allowin_{s+1}).
REQ-009 Stage-register load for stage s (ID..WB) = allowin_s && valid_{s-1} && ready_go_{s-1}; combinational, same cycle.
REQ-010 valid_s (ID..WB) on clk rise: if allowin_s then valid_{s-1} && ready_go_{s-1}, else hold.
REQ-011 if_valid: 1 on every clk rise while not in reset and allowin_IF (pre-IF always requesting); holds when !allowin_IF.
REQ-012 load_use_stall = id_valid && ex_valid && ex_rf_we && ex_res_from_dram && ex_rd != 0 && ((id_use_r1 && id_r1 == ex_rd) || (id_use_r2 && id_r2 == ex_rd)).
REQ-013 flush = ex_valid && ex_br_taken; combinational.
REQ-014 On flush: next cycle id_valid = 0, if_valid = 0, ex_valid = 0 if ex_allowin (bubble replaces wrong-path ID instr); id_load/ex_load still fire but data is discarded.
REQ-015 Flush has priority over load_use_stall and over REQ-010/011 for IF, ID, EX; MEM and WB advance normally in the flush cycle.
REQ-016 Latency: with all ready_go = 1, an instruction valid in IF in cycle n is wb_valid in cycle n+4.
REQ-017 A stalled stage keeps its valid and asserts no load into itself; the stage behind it sees allowin = 0 (backpressure propagates in the same cycle).
REQ-018 mem_ready_go output equals MEM ready_go of REQ-007 (drives MEM/WB register enable).
REQ-019 stall_cnt increments by 1 on each clk rise where load_use_stall || (mem_valid && !mem_ready_go); saturates at 0xFFFF, never wraps.
REQ-020 mem_data_ok while !mem_dram_req SHALL be ignored; mem_dram_req is qualified by mem_valid.

Reset
REQ-021 During rst all valid outputs = 0, all load outputs = 0, flush = 0, load_use_stall = 0, stall_cnt = 0, asynchronously.
REQ-022 First clk rise after rst deassert sets if_valid = 1; no other stage becomes valid before its predecessor held a valid, ready instr.
REQ-023 Reset asserted mid-stall or mid-flush SHALL clear all state immediately; no pending event survives.

Verification
REQ-024 Reset release, all ready = 1 -> if_valid at cycle 1, id_valid 2, ex_valid 3, mem_valid 4, wb_valid 5; stall_cnt = 0.
REQ-025 EX load ex_rd = 5, ID id_r1 = 5 id_use_r1 = 1 -> load_use_stall = 1 one cycle, id_load = 0, ex_valid = 0 next cycle, stall_cnt = 1.
REQ-026 Same as REQ-025 with ex_rd = 0 -> no stall.
REQ-027 mem_dram_req = 1, mem_data_ok low 3 cycles -> mem_ready_go = 0 for 3 cycles, wb_load = 0, EX/ID/IF hold, stall_cnt += 3.
REQ-028 ex_br_taken with ex_valid coincident with load_use_stall -> flush = 1, next cycle if_valid = id_valid = ex_valid = 0, mem_valid = 1.
REQ-029 Preload stall_cnt to 0xFFFE, 3 stall cycles -> stall_cnt = 0xFFFF; assert rst mid-stall -> all outputs 0 without clock edge.
